// File: rtl/aexm_intc_pkg.sv
// aexm_intc_pkg: shared FSM state type, execute-stage opcode constants
// and the safe instruction border check used by the interrupt sequencer.
package aexm_intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        FIRE    = 2'd2,
        SERVICE = 2'd3
    } intcState_t;

    // Opcodes that must not be split from the following instruction
    localparam logic [5:0] OPC_IMM  = 6'o54;
    localparam logic [5:0] OPC_RTD  = 6'o55;
    localparam logic [5:0] OPC_BRU  = 6'o46;
    localparam logic [5:0] OPC_BRUI = 6'o56;
    localparam logic [5:0] OPC_BCC  = 6'o47;
    localparam logic [5:0] OPC_BCCI = 6'o57;

    // An interrupt may only be injected when execute advances, nothing is being
    // flushed, and the current instruction is not an IMM prefix, return or branch.
    function automatic logic safe_border(input logic xEn,
                                         input logic dSkip,
                                         input logic [5:0] opc);
        logic isSpecial;
        isSpecial = (opc == OPC_IMM)  || (opc == OPC_RTD)  ||
                    (opc == OPC_BRU)  || (opc == OPC_BRUI) ||
                    (opc == OPC_BCC)  || (opc == OPC_BCCI);
        return xEn && !dSkip && !isSpecial;
    endfunction

endpackage

// File: rtl/aexm_intc_prio.sv
// aexm_intc_prio: combinational priority encoder. The search begins at
// 'start' and wraps around; the first set request found wins.
module aexm_intc_prio
    import aexm_intc_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Scan from the farthest offset down to 'start' so the nearest request is written last
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/aexm_intc.sv
// aexm_intc: interrupt sequencer for the AEXM core. Picks a pending masked
// request, waits for a safe border in execute, forces a branch to the
// handler vector and then holds off further interrupts until irq_ret.
// Define AEXM_INTC_ROUND_ROBIN_EN for rotating priority; the default build
// uses fixed lowest-index priority.
module aexm_intc
    import aexm_intc_pkg::*;
#(
    parameter int          NREQ  = 8,
    parameter logic [31:0] VBASE = 32'h0000_0010
) (
    input  logic            gclk,
    input  logic            grst,
    input  logic            x_en,
    input  logic [5:0]      rOPC,
    input  logic            dSKIP,
    input  logic [NREQ-1:0] irq_req,
    input  logic            mask_we,
    input  logic [NREQ-1:0] mask_wdata,
    input  logic            irq_ret,
    output logic            cpu_interrupt,
    output logic [31:0]     irq_vector,
    output logic [NREQ-1:0] irq_ack,
    output logic [NREQ-1:0] irq_pend,
    output logic            irq_busy
);

    localparam int IW = $clog2(NREQ);

    intcState_t      r_state;
    intcState_t      w_nextState;
    logic [NREQ-1:0] r_mask;
    logic [IW-1:0]   r_win;
    logic [NREQ-1:0] w_pend;
    logic            w_safe;
    logic            w_prioValid;
    logic [IW-1:0]   w_prioIdx;
    logic [IW-1:0]   w_start;
    logic            w_fireExit;

    assign w_pend     = irq_req & r_mask;
    assign irq_pend   = w_pend;
    assign w_safe     = safe_border(x_en, dSKIP, rOPC);
    assign w_fireExit = (r_state == FIRE) && x_en;

`ifdef AEXM_INTC_ROUND_ROBIN_EN
    logic [IW-1:0] r_ptr;

    // Rotate the search start to just past the line that was serviced
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_ptr <= '0;
        end else if (w_fireExit) begin
            r_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    aexm_intc_prio #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_prio (
        .req   (w_pend),
        .start (w_start),
        .valid (w_prioValid),
        .idx   (w_prioIdx)
    );

    // Mask register, written by software and effective from the next cycle
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_mask <= '0;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    // Capture the winning line when leaving IDLE; it stays fixed through ARM and FIRE
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_win <= '0;
        end else if ((r_state == IDLE) && w_prioValid) begin
            r_win <= w_prioIdx;
        end
    end

    // State register
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; ARM gives up if its chosen line is withdrawn or masked
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_prioValid) begin
                    w_nextState = ARM;
                end
            end
            ARM: begin
                if (!w_pend[r_win]) begin
                    w_nextState = IDLE;
                end else if (w_safe) begin
                    w_nextState = FIRE;
                end
            end
            FIRE: begin
                if (x_en) begin
                    w_nextState = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_ret) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs decoded from the state and win flops, so reset clears them at once
    always_comb begin
        cpu_interrupt = (r_state == FIRE);
        irq_busy      = (r_state == SERVICE);
        irq_vector    = '0;
        irq_ack       = '0;
        if (r_state == FIRE) begin
            irq_vector = VBASE + (32'(r_win) << 3);
        end
        if (w_fireExit) begin
            irq_ack = {{(NREQ - 1){1'b0}}, 1'b1} << r_win;
        end
    end

endmodule

// File: tb/tb_aexm_intc.sv
// tb_aexm_intc: directed self-checking bench for aexm_intc with
// hand-computed expected values (NREQ=8, VBASE=32'h10).
module tb_aexm_intc;

    logic        gclk;
    logic        grst;
    logic        x_en;
    logic [5:0]  rOPC;
    logic        dSKIP;
    logic [7:0]  irq_req;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        irq_ret;
    logic        cpu_interrupt;
    logic [31:0] irq_vector;
    logic [7:0]  irq_ack;
    logic [7:0]  irq_pend;
    logic        irq_busy;

    int assertCount = 0;
    int failCount   = 0;

    aexm_intc #(
        .NREQ  (8),
        .VBASE (32'h0000_0010)
    ) dut (
        .gclk          (gclk),
        .grst          (grst),
        .x_en          (x_en),
        .rOPC          (rOPC),
        .dSKIP         (dSKIP),
        .irq_req       (irq_req),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .irq_ret       (irq_ret),
        .cpu_interrupt (cpu_interrupt),
        .irq_vector    (irq_vector),
        .irq_ack       (irq_ack),
        .irq_pend      (irq_pend),
        .irq_busy      (irq_busy)
    );

    // Free-running core clock
    initial begin
        gclk = 1'b0;
        forever #5 gclk = ~gclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic applyStimulus();
        @(posedge gclk);
        #1;
    endtask

    task automatic serviceReturn();
        irq_ret = 1'b1;
        applyStimulus();
        irq_ret = 1'b0;
    endtask

    initial begin
        logic [7:0] expAck;
        grst       = 1'b1;
        x_en       = 1'b1;
        rOPC       = 6'o00;
        dSKIP      = 1'b0;
        irq_req    = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        irq_ret    = 1'b0;
        #1;
        checkOutput("rst_cpu_int", 32'(cpu_interrupt), 32'd0);
        checkOutput("rst_vector", irq_vector, 32'h0);
        checkOutput("rst_ack", 32'(irq_ack), 32'h0);
        checkOutput("rst_busy", 32'(irq_busy), 32'd0);
        checkOutput("rst_pend", 32'(irq_pend), 32'h0);
        applyStimulus();
        applyStimulus();
        grst = 1'b0;
        applyStimulus();

        $display("[TB] basic request on lines 2 and 5");
        mask_we    = 1'b1;
        mask_wdata = 8'hFF;
        applyStimulus();
        mask_we = 1'b0;
        irq_req = 8'h24;
        #1;
        checkOutput("t1_pend", 32'(irq_pend), 32'h24);
        applyStimulus();
        checkOutput("t1_arm_no_int", 32'(cpu_interrupt), 32'd0);
        applyStimulus();
        checkOutput("t1_fire_int", 32'(cpu_interrupt), 32'd1);
        checkOutput("t1_fire_vector", irq_vector, 32'h20);
        checkOutput("t1_fire_ack", 32'(irq_ack), 32'h04);
        applyStimulus();
        irq_req = 8'h00;
        checkOutput("t1_svc_ack", 32'(irq_ack), 32'h00);
        checkOutput("t1_svc_busy", 32'(irq_busy), 32'd1);
        checkOutput("t1_svc_int", 32'(cpu_interrupt), 32'd0);
        applyStimulus();
        checkOutput("t1_svc_hold", 32'(irq_busy), 32'd1);
        serviceReturn();
        checkOutput("t1_ret_busy", 32'(irq_busy), 32'd0);

        $display("[TB] IMM in execute blocks the interrupt");
        rOPC    = 6'o54;
        irq_req = 8'h01;
        applyStimulus();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("t2_imm_no_int", 32'(cpu_interrupt), 32'd0);
        end
        rOPC = 6'o00;
        applyStimulus();
        checkOutput("t2_fire_int", 32'(cpu_interrupt), 32'd1);
        checkOutput("t2_fire_vector", irq_vector, 32'h10);
        checkOutput("t2_fire_ack", 32'(irq_ack), 32'h01);
        applyStimulus();
        irq_req = 8'h00;
        serviceReturn();

        $display("[TB] request withdrawn during ARM");
        rOPC    = 6'o55;
        irq_req = 8'h08;
        applyStimulus();
        checkOutput("t3_arm_ack", 32'(irq_ack), 32'h00);
        irq_req = 8'h00;
        applyStimulus();
        rOPC = 6'o00;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("t3_abort_int", 32'(cpu_interrupt), 32'd0);
            checkOutput("t3_abort_ack", 32'(irq_ack), 32'h00);
            checkOutput("t3_abort_busy", 32'(irq_busy), 32'd0);
        end

        $display("[TB] FIRE stalled by x_en");
        irq_req = 8'h10;
        applyStimulus();
        applyStimulus();
        x_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("t4_hold_int", 32'(cpu_interrupt), 32'd1);
            checkOutput("t4_hold_vector", irq_vector, 32'h30);
            checkOutput("t4_hold_ack", 32'(irq_ack), 32'h00);
            applyStimulus();
        end
        x_en = 1'b1;
        #1;
        checkOutput("t4_release_ack", 32'(irq_ack), 32'h10);
        applyStimulus();
        irq_req = 8'h00;
        checkOutput("t4_single_ack", 32'(irq_ack), 32'h00);
        checkOutput("t4_busy", 32'(irq_busy), 32'd1);
        serviceReturn();

        $display("[TB] lines 1 and 2 held high");
        irq_req = 8'h06;
        for (int i = 0; i < 4; i++) begin
`ifdef AEXM_INTC_ROUND_ROBIN_EN
            expAck = (i % 2 == 0) ? 8'h02 : 8'h04;
`else
            expAck = 8'h02;
`endif
            applyStimulus();
            applyStimulus();
            checkOutput("t5_arb_ack", 32'(irq_ack), 32'(expAck));
            checkOutput("t5_arb_int", 32'(cpu_interrupt), 32'd1);
            applyStimulus();
            serviceReturn();
        end
        irq_req = 8'h00;
        applyStimulus();
        applyStimulus();

        $display("[TB] reset mid-FIRE");
        irq_req = 8'h01;
        applyStimulus();
        applyStimulus();
        x_en = 1'b0;
        #1;
        checkOutput("t6_fire_int", 32'(cpu_interrupt), 32'd1);
        grst = 1'b1;
        #1;
        checkOutput("t6_rst_int", 32'(cpu_interrupt), 32'd0);
        checkOutput("t6_rst_vector", irq_vector, 32'h0);
        checkOutput("t6_rst_mask", 32'(irq_pend), 32'h00);
        applyStimulus();
        grst = 1'b0;
        x_en = 1'b1;
        applyStimulus();
        checkOutput("t6_after_int", 32'(cpu_interrupt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
